ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 126 ++++++++++++
 tb/tb_ifu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch with redirect handling.
// Responses for requests issued before a redirect are counted off and discarded.
module ifu #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_tvalid,
    input  logic        imem_req_tready,
    output logic [31:0] imem_req_tdata,
    input  logic        imem_rsp_tvalid,
    output logic        imem_rsp_tready,
    input  logic [31:0] imem_rsp_tdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_tvalid,
    input  logic        ifid_tready,
    output logic [63:0] ifid_tdata
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST  = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [31:0]   resp_pc;
    logic          held;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [63:0]   fifo [MAX_OUTSTANDING];

    logic          credit_ok;
    logic          new_req;
    logic          req_fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          held_next;
    logic [CW-1:0] out_next;
    logic [31:0]   redir_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign credit_ok       = ({1'b0, outstanding} + {1'b0, count}) < LIMIT;
    assign imem_req_tvalid = rst && (held || credit_ok);
    assign imem_req_tdata  = held ? req_addr : fetch_pc;
    assign imem_rsp_tready = 1'b1;

    assign new_req   = imem_req_tvalid && !held;
    assign req_fire  = imem_req_tvalid && imem_req_tready;
    assign held_next = imem_req_tvalid && !imem_req_tready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok    = imem_rsp_tvalid && (outstanding != '0);
    assign push      = rsp_ok && !redirect_valid && (drop_cnt == '0);
    assign out_next  = outstanding + CW'(req_fire) - CW'(rsp_ok);
    assign redir_pc  = {redirect_pc[31:2], 2'b00};

    assign ifid_tvalid = rst && (count != '0) && !redirect_valid;
    assign ifid_tdata  = fifo[rd_ptr];
    assign pop         = ifid_tvalid && ifid_tready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            req_addr    <= RESET_PC;
            resp_pc     <= RESET_PC;
            held        <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            held        <= held_next;
            // A newly presented address is claimed immediately; if it stalls it
            // lives on in req_addr so a redirect cannot change it.
            if (new_req) begin
                req_addr <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
                drop_cnt <= out_next + CW'(held_next);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (new_req) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo[wr_ptr] <= {resp_pc, imem_rsp_tdata};
        end
    end

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_tvalid && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: in-order memory model returning ~addr as the instruction,
// scenarios for streaming, back-pressure, redirect with outstanding/held requests, wrap.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_tvalid;
    logic        imem_req_tready;
    logic [31:0] imem_req_tdata;
    logic        imem_rsp_tvalid;
    logic        imem_rsp_tready;
    logic [31:0] imem_rsp_tdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_tvalid;
    logic        ifid_tready;
    logic [63:0] ifid_tdata;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h8000_0000), .MAX_OUTSTANDING(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_tvalid (imem_req_tvalid),
        .imem_req_tready (imem_req_tready),
        .imem_req_tdata  (imem_req_tdata),
        .imem_rsp_tvalid (imem_rsp_tvalid),
        .imem_rsp_tready (imem_rsp_tready),
        .imem_rsp_tdata  (imem_rsp_tdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ifid_tvalid     (ifid_tvalid),
        .ifid_tready     (ifid_tready),
        .ifid_tdata      (ifid_tdata)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [63:0] ifid_log[$];
    logic        mem_rsp_en = 1'b1;
    logic        fire_req   = 1'b0;
    logic        fire_rsp   = 1'b0;
    logic [31:0] fire_addr  = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] ifid_at(input int i);
        return (i < ifid_log.size()) ? ifid_log[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    // Handshakes are observed mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        fire_req  = imem_req_tvalid && imem_req_tready;
        fire_addr = imem_req_tdata;
        fire_rsp  = imem_rsp_tvalid && imem_rsp_tready;
        if (fire_req) req_log.push_back(imem_req_tdata);
        if (ifid_tvalid && ifid_tready) ifid_log.push_back(ifid_tdata);
    end

    // In-order memory: a request accepted at one edge is offered back the next cycle.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            mem_q.delete();
        end else begin
            if (fire_rsp && mem_q.size() > 0) void'(mem_q.pop_front());
            if (fire_req) mem_q.push_back(fire_addr);
        end
        imem_rsp_tvalid = rst && mem_rsp_en && (mem_q.size() > 0);
        imem_rsp_tdata  = (mem_q.size() > 0) ? ~mem_q[0] : 32'h0;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(2);
        @(negedge clk);
        check_eq("rst_req_valid", 64'(imem_req_tvalid), 64'd0);
        check_eq("rst_ifid_valid", 64'(ifid_tvalid), 64'd0);
        check_eq("rst_rsp_ready", 64'(imem_rsp_tready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_log.delete();
        ifid_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst             = 1'b0;
        imem_req_tready = 1'b1;
        imem_rsp_tvalid = 1'b0;
        imem_rsp_tdata  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        ifid_tready     = 1'b1;
        step(1);

        // Streaming fetch out of reset
        mem_rsp_en = 1'b1; imem_req_tready = 1'b1; ifid_tready = 1'b1;
        do_reset();
        @(negedge clk);
        check_eq("first_req_valid", 64'(imem_req_tvalid), 64'd1);
        check_eq("first_req_addr", 64'(imem_req_tdata), 64'h8000_0000);
        step(10);
        check_eq("stream_req_cnt", 64'(req_log.size()), 64'd10);
        check_eq("stream_ifid_cnt", 64'(ifid_log.size()), 64'd8);
        check_eq("stream_req1", 64'(req_at(1)), 64'h8000_0004);
        check_eq("stream_req2", 64'(req_at(2)), 64'h8000_0008);
        check_eq("stream_req9", 64'(req_at(9)), 64'h8000_0024);
        check_eq("stream_ifid0", ifid_at(0), {32'h8000_0000, 32'h7FFF_FFFF});
        check_eq("stream_ifid7", ifid_at(7), {32'h8000_001C, 32'h7FFF_FFE3});

        // Decoder stalled: credits cap in-flight work at four
        ifid_tready = 1'b0;
        do_reset();
        step(10);
        check_eq("stall_req_cnt", 64'(req_log.size()), 64'd4);
        @(negedge clk);
        check_eq("stall_no_req", 64'(imem_req_tvalid), 64'd0);
        check_eq("stall_ifid_valid", 64'(ifid_tvalid), 64'd1);
        check_eq("stall_ifid_head", ifid_tdata, {32'h8000_0000, 32'h7FFF_FFFF});
        step(1);
        ifid_tready = 1'b1;
        step(1);
        ifid_tready = 1'b0;
        step(4);
        check_eq("stall_req_cnt2", 64'(req_log.size()), 64'd5);
        check_eq("stall_req4", 64'(req_at(4)), 64'h8000_0010);
        check_eq("stall_pop_cnt", 64'(ifid_log.size()), 64'd1);
        check_eq("stall_pop0", ifid_at(0), {32'h8000_0000, 32'h7FFF_FFFF});
        @(negedge clk);
        check_eq("stall_no_req2", 64'(imem_req_tvalid), 64'd0);

        // Redirect with three requests outstanding and one buffered instruction
        ifid_tready = 1'b0; mem_rsp_en = 1'b1; imem_req_tready = 1'b1;
        do_reset();
        step(2);
        mem_rsp_en = 1'b0;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        @(negedge clk);
        check_eq("r3_ifid_suppr", 64'(ifid_tvalid), 64'd0);
        check_eq("r3_no_req", 64'(imem_req_tvalid), 64'd0);
        step(1);
        redirect_valid = 1'b0;
        ifid_tready    = 1'b1;
        mem_rsp_en     = 1'b1;
        step(8);
        check_eq("r3_req3", 64'(req_at(3)), 64'h8000_000C);
        check_eq("r3_req4", 64'(req_at(4)), 64'h0000_1000);
        check_eq("r3_ifid0", ifid_at(0), {32'h0000_1000, 32'hFFFF_EFFF});
        check_eq("r3_ifid1", ifid_at(1), {32'h0000_1004, 32'hFFFF_EFFB});

        // Redirect while a request is held by a stalled memory
        ifid_tready = 1'b1; mem_rsp_en = 1'b1; imem_req_tready = 1'b1;
        do_reset();
        step(4);
        imem_req_tready = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        @(negedge clk);
        check_eq("held_valid", 64'(imem_req_tvalid), 64'd1);
        check_eq("held_addr", 64'(imem_req_tdata), 64'h8000_0010);
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("held_addr_after", 64'(imem_req_tdata), 64'h8000_0010);
        step(1);
        imem_req_tready = 1'b1;
        step(6);
        check_eq("held_req4", 64'(req_at(4)), 64'h8000_0010);
        check_eq("held_req5", 64'(req_at(5)), 64'h0000_1000);
        check_eq("held_ifid2", ifid_at(2), {32'h8000_0008, 32'h7FFF_FFF7});
        check_eq("held_ifid3", ifid_at(3), {32'h0000_1000, 32'hFFFF_EFFF});

        // Redirect mid-stream, colliding with a response, into the wrap point
        ifid_tready = 1'b1; mem_rsp_en = 1'b1; imem_req_tready = 1'b1;
        do_reset();
        step(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        check_eq("wrap_ifid_suppr", 64'(ifid_tvalid), 64'd0);
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("wrap_fifo_flushed", 64'(ifid_tvalid), 64'd0);
        step(8);
        check_eq("wrap_ifid2", ifid_at(2), {32'h8000_0008, 32'h7FFF_FFF7});
        check_eq("wrap_ifid3", ifid_at(3), {32'hFFFF_FFF8, 32'h0000_0007});
        check_eq("wrap_ifid4", ifid_at(4), {32'hFFFF_FFFC, 32'h0000_0003});
        check_eq("wrap_ifid5", ifid_at(5), {32'h0000_0000, 32'hFFFF_FFFF});
        check_eq("wrap_req8", 64'(req_at(8)), 64'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
